sprite_blitter: RTL
===================

// Module: sprite_blitter
// PURPOSE
//  Writer side of the sprite path: copies a 32x32 1-bit sprite ROM (e.g. bloonpop_rom) into a
//  palette-index frame buffer at a requested screen position, one pixel per handshake.
//  ROM '1' pixels are written with a caller-supplied colour index. '0' pixels are transparent.
//  Sits between game logic (start/pos) and the frame-buffer RAM write port that the VGA scan-out reads.
// PARAMETERS
//  SPR_W   32      sprite width, pixels (power of 2)
//  SPR_H   32      sprite height, pixels
//  FB_W    320     frame buffer width, pixels
//  FB_H    240     frame buffer height, pixels
//  FB_AW   17      frame buffer address width (>= clog2(FB_W*FB_H))
//  PIX_W   4       palette index width written to frame buffer
// PORTS
//  vga_clk      in   1       single clock, all logic rising-edge
//  reset        in   1       synchronous, active-high
//  start        in   1       request blit; sampled only in IDLE
//  pos_x        in   10      sprite top-left X, latched on accepted start
//  pos_y        in   10      sprite top-left Y, latched on accepted start
//  color        in   PIX_W   index written for opaque pixels, latched on accepted start
//  busy         out  1       high from accepted start until DONE exits
//  done         out  1       one-cycle pulse when the blit completes
//  rom_address  out  10      sprite ROM address = ry*SPR_W + rx; registered
//  rom_q        in   1       sprite ROM data, 1-cycle latency after rom_address
//  fb_we        out  1       frame buffer write request
//  fb_addr      out  FB_AW   write address = (pos_y+ry)*FB_W + (pos_x+rx)
//  fb_data      out  PIX_W   write data (latched color)
//  fb_ready     in   1       RAM accepts write on an edge where fb_we && fb_ready
// BEHAVIOUR
//  Reset: state IDLE; busy, done, fb_we = 0; rom_address, fb_addr, fb_data = 0; rx, ry = 0.
//  All outputs are registered. The bus is synchronous: at most one write accepted per edge.
//  FSM states are IDLE, FETCH, EVAL, WRITE, DONE.
//   IDLE : on start=1, latch pos_x/pos_y/color, rx=ry=0, rom_address<=0, busy<=1, go FETCH.
//   FETCH: ROM samples rom_address at this edge. Always go EVAL.
//   EVAL : rom_q valid. If rom_q=1 and X<FB_W and Y<FB_H (X=pos_x+rx, Y=pos_y+ry), load
//          fb_addr/fb_data, fb_we<=1, go WRITE. Otherwise skip the pixel (advance).
//   WRITE: hold fb_we/fb_addr/fb_data stable while fb_ready=0. On an edge with fb_ready=1,
//          fb_we<=0, then advance.
//   advance: if rx==SPR_W-1 and ry==SPR_H-1, go DONE. Otherwise rx++ (wrap to 0 with ry++),
//          set rom_address to the new pixel, go FETCH.
//   DONE : done=1 for exactly this cycle, busy<=0, go IDLE. A new start is accepted the
//          next cycle.
//  Clipping: X and Y are computed at 11 bits, so there is no wrap-around. Off-screen pixels
//   produce no write and cost 2 cycles. Negative positions are not supported.
//  Timing with fb_ready held 1: opaque on-screen pixel = 3 cycles; skipped pixel = 2 cycles.
//   Full opaque blit = 3*SPR_W*SPR_H cycles in FETCH/EVAL/WRITE, plus 1 DONE cycle.
//  Pixel order is row-major, rx fastest. fb_addr uses a constant multiply by FB_W.
//  start while busy is ignored, with no queueing. pos/color changes after start have no effect.
//  reset mid-blit: at the next edge return to IDLE with all outputs at reset values. fb_we
//   drops immediately and no done pulse is issued.
// TESTING
//  1 All-ones ROM, pos (0,0), fb_ready=1, color=4'hA -> 1024 writes. Addrs 0..31, 320..351,
//    ..., 9920..9951, data 4'hA. done is pulsed once, 3073 cycles after start.
//  2 All-ones ROM, pos (300,220) -> writes only for rx 0..19, ry 0..19 (400 writes).
//    Last addr is 239*320+319 = 76799. No write has X>=320 or Y>=240.
//  3 All-zeros ROM, pos (10,10) -> fb_we never asserted. done 2049 cycles after start.
//  4 Checkerboard ROM, fb_ready low for 5 cycles on the first write -> fb_we, fb_addr (=0),
//    and fb_data are held stable for all 5 cycles. 512 writes total, each accepted once.
//  5 Pulse start again at cycle 100 with pos (50,50) -> ignored. All writes use the first
//    position. busy stays high until done.
//  6 Assert reset at write #200 -> next cycle fb_we=0, busy=0, and no done pulse. A fresh
//    start afterwards blits correctly from pixel 0.

Source files
------------

// File: rtl/sprite_blitter_if.sv
// Frame-buffer write port between the sprite blitter (master) and the frame-buffer RAM (slave).
// Handshake: a write is accepted on a rising edge where fb_we && fb_ready; while fb_ready is low the master holds fb_we/fb_addr/fb_data stable.
interface sprite_blitter_if #(
    parameter int FB_AW = 17,
    parameter int PIX_W = 4
);
    logic             fb_we;
    logic [FB_AW-1:0] fb_addr;
    logic [PIX_W-1:0] fb_data;
    logic             fb_ready;

    modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/sprite_blitter.sv
// Copies a 1-bit sprite ROM into a palette-index frame buffer at (pos_x, pos_y), one pixel per write.
// Opaque ROM pixels are written with the latched colour; transparent and off-screen pixels are skipped.
module sprite_blitter #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int FB_W  = 320,
    parameter int FB_H  = 240,
    parameter int FB_AW = 17,
    parameter int PIX_W = 4
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic [PIX_W-1:0] color,
    output logic             busy,
    output logic             done,
    output logic [9:0]       rom_address,
    input  logic             rom_q,
    sprite_blitter_if.master fb,
    output logic [2:0]       dbg_state
);
    localparam int RX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [RX_W-1:0]  rx_q, rx_d;
    logic [RY_W-1:0]  ry_q, ry_d;
    logic [9:0]       pos_x_q, pos_x_d;
    logic [9:0]       pos_y_q, pos_y_d;
    logic [PIX_W-1:0] color_q, color_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [9:0]       rom_address_q, rom_address_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0] fb_data_q, fb_data_d;

    logic [10:0]      x_pos, y_pos;
    logic             on_screen;
    logic             last_px;
    logic             advance;
    logic [RX_W-1:0]  rx_nxt;
    logic [RY_W-1:0]  ry_nxt;

    // 11-bit screen coordinates so a sprite near the right/bottom edge cannot wrap back on-screen.
    assign x_pos     = 11'(pos_x_q) + 11'(rx_q);
    assign y_pos     = 11'(pos_y_q) + 11'(ry_q);
    assign on_screen = (x_pos < 11'(FB_W)) && (y_pos < 11'(FB_H));
    assign last_px   = (rx_q == RX_W'(SPR_W - 1)) && (ry_q == RY_W'(SPR_H - 1));

    always_comb begin
        if (rx_q == RX_W'(SPR_W - 1)) begin
            rx_nxt = '0;
            ry_nxt = ry_q + RY_W'(1);
        end else begin
            rx_nxt = rx_q + RX_W'(1);
            ry_nxt = ry_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        rx_d          = rx_q;
        ry_d          = ry_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        color_d       = color_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        rom_address_d = rom_address_q;
        fb_we_d       = fb_we_q;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        advance       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pos_x_d       = pos_x;
                    pos_y_d       = pos_y;
                    color_d       = color;
                    rx_d          = '0;
                    ry_d          = '0;
                    rom_address_d = '0;
                    busy_d        = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EVAL;
            ST_EVAL: begin
                if (rom_q && on_screen) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = FB_AW'(y_pos * FB_W + x_pos);
                    fb_data_d = color_q;
                    state_d   = ST_WRITE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WRITE: begin
                if (fb.fb_ready) begin
                    fb_we_d = 1'b0;
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared pixel step for both skipped and written pixels; row-major, rx fastest.
        if (advance) begin
            if (last_px) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                rx_d          = rx_nxt;
                ry_d          = ry_nxt;
                rom_address_d = 10'(int'(ry_nxt) * SPR_W + int'(rx_nxt));
                state_d       = ST_FETCH;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rx_q          <= '0;
            ry_q          <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            color_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rom_address_q <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            rx_q          <= rx_d;
            ry_q          <= ry_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            color_q       <= color_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rom_address_q <= rom_address_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rom_address = rom_address_q;
    assign fb.fb_we    = fb_we_q;
    assign fb.fb_addr  = fb_addr_q;
    assign fb.fb_data  = fb_data_q;
    assign dbg_state   = state_q;
endmodule
